tw_slave_regbank: RTL and testbench



---
 rtl/tw_pkg.sv | 20 ++
 rtl/tw_sync_edge.sv | 41 ++++
 rtl/tw_slave_regbank.sv | 187 ++++++++++++++++++
 tb/tb_tw_slave_regbank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tw_pkg.sv
// Shared definitions for the three-wire bus master and slave.
package tw_pkg;

  // Slave frame-decoder state encoding.
  localparam logic [2:0] TW_ST_IDLE  = 3'd0;
  localparam logic [2:0] TW_ST_CMD   = 3'd1;
  localparam logic [2:0] TW_ST_ADDR  = 3'd2;
  localparam logic [2:0] TW_ST_TURN  = 3'd3;
  localparam logic [2:0] TW_ST_WDATA = 3'd4;
  localparam logic [2:0] TW_ST_RDATA = 3'd5;
  localparam logic [2:0] TW_ST_DONE  = 3'd6;

  // Value of the leading R/W bit of a frame.
  localparam logic TW_RW_WRITE = 1'b1;
  localparam logic TW_RW_READ  = 1'b0;

  // Shortest legal tw clock half-period / cs setup-hold, in local clock cycles.
  localparam int unsigned TW_MIN_HALF_PERIOD = 4;

endpackage

// File: rtl/tw_sync_edge.sv
// Two-flop synchronizer for one asynchronous bus line, plus registered
// rising/falling edge pulses (3 local cycles from bus edge to pulse).
module tw_sync_edge (
  input  logic in_clk,
  input  logic in_reset,
  input  logic in_async,
  output logic out_level,
  output logic out_rise,
  output logic out_fall
);

  // [0] first sync stage, [1] second sync stage, [2] previous synced value
  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // Shift the line through the chain and compare the last two stages.
  always_comb begin
    sync_d = {sync_q[1:0], in_async};
    rise_d = sync_q[1] & ~sync_q[2];
    fall_d = ~sync_q[1] & sync_q[2];
  end

  // State registers.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_level = sync_q[1];
  assign out_rise  = rise_q;
  assign out_fall  = fall_q;

endmodule

// File: rtl/tw_slave_regbank.sv
// Three-wire bus slave serving a bank of REG_COUNT registers. Frames are
// decoded from oversampled bus lines; every completed write is also reported
// to local logic on the out_wr_* port.
module tw_slave_regbank #(
  parameter int TWS_ADDRESS_BITS = 16,
  parameter int TWS_DATA_BITS    = 32,
  parameter int REG_COUNT        = 16
) (
  input  logic                        in_clk,
  input  logic                        in_reset,
  input  logic                        in_tw_clock,
  input  logic                        in_tw_cs,
  inout  wire                         io_tw_data,
  output logic                        out_wr_valid,
  output logic [TWS_ADDRESS_BITS-1:0] out_wr_addr,
  output logic [TWS_DATA_BITS-1:0]    out_wr_data,
  output logic                        out_frame_err
);
  import tw_pkg::*;

  localparam int AB    = TWS_ADDRESS_BITS;
  localparam int DB    = TWS_DATA_BITS;
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int CNT_W = $clog2((AB > DB) ? AB : DB);

  // Synchronized bus events.
  logic clk_rise, clk_fall, cs_rise, cs_fall, data_lvl;
  logic clk_level_unused, cs_level_unused, data_rise_unused, data_fall_unused;

  tw_sync_edge u_sync_clk (
    .in_clk(in_clk), .in_reset(in_reset), .in_async(in_tw_clock),
    .out_level(clk_level_unused), .out_rise(clk_rise), .out_fall(clk_fall)
  );

  tw_sync_edge u_sync_cs (
    .in_clk(in_clk), .in_reset(in_reset), .in_async(in_tw_cs),
    .out_level(cs_level_unused), .out_rise(cs_rise), .out_fall(cs_fall)
  );

  tw_sync_edge u_sync_data (
    .in_clk(in_clk), .in_reset(in_reset), .in_async(io_tw_data),
    .out_level(data_lvl), .out_rise(data_rise_unused), .out_fall(data_fall_unused)
  );

  // Frame decoder and register bank state.
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [AB-1:0]    addr_q, addr_d;
  logic [DB-1:0]    shreg_q, shreg_d;   // write data in, read data out
  logic             oe_q, oe_d;
  logic             wr_valid_q, wr_valid_d;
  logic [AB-1:0]    wr_addr_q, wr_addr_d;
  logic [DB-1:0]    wr_data_q, wr_data_d;
  logic             err_q, err_d;
  logic [DB-1:0]    regs_q [REG_COUNT];
  logic [DB-1:0]    regs_d [REG_COUNT];

  logic [AB-1:0]    addr_next;
  logic [DB-1:0]    data_next;

  // An address hits the bank only when every bit above the index is zero.
  function automatic logic addr_hit(input logic [AB-1:0] a);
    return a[AB-1:IDX_W] == '0;
  endfunction

  // Next-state logic for the frame decoder, shift register and bank.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    oe_d       = oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    regs_d     = regs_q;
    addr_next  = {addr_q[AB-2:0], data_lvl};
    data_next  = {shreg_q[DB-2:0], data_lvl};

    if (cs_fall) begin
      // cs low ends any frame; only an unfinished one is reported as aborted.
      state_d = TW_ST_IDLE;
      oe_d    = 1'b0;
      err_d   = (state_q != TW_ST_IDLE) && (state_q != TW_ST_DONE);
    end else begin
      case (state_q)
        TW_ST_IDLE: if (cs_rise) begin
          state_d = TW_ST_CMD;
          cnt_d   = '0;
        end
        TW_ST_CMD: if (clk_rise) begin
          rw_d    = data_lvl;
          state_d = TW_ST_ADDR;
          cnt_d   = '0;
        end
        TW_ST_ADDR: if (clk_rise) begin
          addr_d = addr_next;
          if (cnt_q == CNT_W'(AB - 1)) begin
            cnt_d = '0;
            if (rw_q == TW_RW_WRITE) begin
              state_d = TW_ST_WDATA;
            end else begin
              // Snapshot the register now so later writes cannot disturb this read.
              state_d = TW_ST_TURN;
              shreg_d = addr_hit(addr_next) ? regs_q[addr_next[IDX_W-1:0]] : '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        TW_ST_TURN: if (clk_fall) begin
          state_d = TW_ST_RDATA;
          oe_d    = 1'b1;
        end
        TW_ST_RDATA: begin
          if (clk_fall) begin
            shreg_d = {shreg_q[DB-2:0], 1'b0};
          end else if (clk_rise) begin
            if (cnt_q == CNT_W'(DB - 1)) begin
              state_d = TW_ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        TW_ST_WDATA: if (clk_rise) begin
          shreg_d = data_next;
          if (cnt_q == CNT_W'(DB - 1)) begin
            state_d    = TW_ST_DONE;
            cnt_d      = '0;
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = data_next;
            if (addr_hit(addr_q)) regs_d[addr_q[IDX_W-1:0]] = data_next;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        TW_ST_DONE: if (clk_fall) oe_d = 1'b0;
        default: state_d = TW_ST_IDLE;
      endcase
    end
  end

  // State registers, including the register bank.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      state_q    <= TW_ST_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      shreg_q    <= '0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      // NOTE: the bank is a small flop array that must read as zero after reset, so it is reset here.
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      shreg_q    <= shreg_d;
      oe_q       <= oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      regs_q     <= regs_d;
    end
  end

  assign io_tw_data    = oe_q ? shreg_q[DB-1] : 1'bz;
  assign out_wr_valid  = wr_valid_q;
  assign out_wr_addr   = wr_addr_q;
  assign out_wr_data   = wr_data_q;
  assign out_frame_err = err_q;

endmodule

// File: tb/tb_tw_slave_regbank.sv
// Self-checking bench: acts as the bus master and compares reads, commits and
// abort pulses against an array model of the register bank.
module tb_tw_slave_regbank;
  import tw_pkg::*;

  localparam int AB = 16;
  localparam int DB = 32;
  localparam int RC = 16;

  logic          in_clk = 1'b0;
  logic          in_reset = 1'b1;
  logic          in_tw_clock = 1'b0;
  logic          in_tw_cs = 1'b0;
  logic          tb_oe = 1'b0;
  logic          tb_bit = 1'b0;
  wire           io_tw_data;
  logic          out_wr_valid;
  logic [AB-1:0] out_wr_addr;
  logic [DB-1:0] out_wr_data;
  logic          out_frame_err;

  // Master side of the data line; the pull-up makes an undriven line read 1.
  assign io_tw_data = tb_oe ? tb_bit : 1'bz;
  pullup (io_tw_data);

  always #5 in_clk = ~in_clk;

  tw_slave_regbank #(
    .TWS_ADDRESS_BITS(AB), .TWS_DATA_BITS(DB), .REG_COUNT(RC)
  ) dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_tw_clock(in_tw_clock),
    .in_tw_cs(in_tw_cs), .io_tw_data(io_tw_data), .out_wr_valid(out_wr_valid),
    .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .out_frame_err(out_frame_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  int h = TW_MIN_HALF_PERIOD;
  int wr_seen = 0;
  int err_seen = 0;
  int exp_wr = 0;
  int exp_err = 0;
  logic [AB-1:0] exp_addr = '0;
  logic [DB-1:0] exp_data = '0;
  logic [DB-1:0] model [RC];

  // Count output pulses, sampled away from the active edge.
  always @(negedge in_clk) begin
    if (out_wr_valid) wr_seen++;
    if (out_frame_err) err_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  function automatic logic [DB-1:0] model_read(input logic [AB-1:0] a);
    return (a < RC) ? model[a] : '0;
  endfunction

  task automatic send_bit(input logic b);
    tb_oe = 1'b1;
    tb_bit = b;
    tick(h);
    in_tw_clock = 1'b1;
    tick(h);
    in_tw_clock = 1'b0;
  endtask

  // cs high, R/W bit, then the top nbits of the address.
  task automatic send_hdr(input logic rw, input logic [AB-1:0] a, input int nbits);
    in_tw_cs = 1'b1;
    tick(h);
    send_bit(rw);
    for (int i = AB - 1; i >= AB - nbits; i--) send_bit(a[i]);
  endtask

  task automatic end_frame();
    tb_oe = 1'b0;
    tick(h);
    in_tw_cs = 1'b0;
    tick(h + 2);
  endtask

  task automatic bus_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input int extra);
    send_hdr(TW_RW_WRITE, a, AB);
    for (int i = DB - 1; i >= 0; i--) send_bit(d[i]);
    tb_oe = 1'b0;
    for (int k = 0; k < extra; k++) begin
      tick(h);
      check("extra_clk_line_lo", io_tw_data, 1'b1);
      in_tw_clock = 1'b1;
      tick(h);
      check("extra_clk_line_hi", io_tw_data, 1'b1);
      in_tw_clock = 1'b0;
    end
    end_frame();
    if (a < RC) model[a] = d;
    exp_wr++;
    exp_addr = a;
    exp_data = d;
    check("wr_count", wr_seen, exp_wr);
    check("wr_addr", out_wr_addr, exp_addr);
    check("wr_data", out_wr_data, exp_data);
  endtask

  task automatic bus_read(input logic [AB-1:0] a);
    logic [DB-1:0] d;
    send_hdr(TW_RW_READ, a, AB);
    tb_oe = 1'b0;
    for (int i = DB - 1; i >= 0; i--) begin
      tick(h);
      d[i] = io_tw_data;
      in_tw_clock = 1'b1;
      tick(h);
      in_tw_clock = 1'b0;
    end
    end_frame();
    check($sformatf("rd_0x%04h", a), d, model_read(a));
    check("rd_line_released", io_tw_data, 1'b1);
    check("rd_wr_addr_held", out_wr_addr, exp_addr);
  endtask

  initial begin
    for (int i = 0; i < RC; i++) model[i] = '0;
    tick(3);
    check("rst_line", io_tw_data, 1'b1);
    check("rst_wr_valid", out_wr_valid, 1'b0);
    check("rst_wr_addr", out_wr_addr, '0);
    check("rst_wr_data", out_wr_data, '0);
    check("rst_frame_err", out_frame_err, 1'b0);
    in_reset = 1'b0;
    tick(4);

    // Basic write then read-back.
    bus_write(16'h0003, 32'hDEAD_BEEF, 0);
    bus_read(16'h0003);

    // Out-of-range accesses.
    bus_write(16'h000B, 32'hCAFE_F00D, 0);
    bus_read(16'h01AA);
    bus_write(16'h01BB, 32'h1234_5678, 0);
    bus_read(16'h000B);

    // Write aborted after 10 address bits.
    send_hdr(TW_RW_WRITE, 16'h0003, 10);
    end_frame();
    exp_err++;
    check("abort_err_count", err_seen, exp_err);
    check("abort_no_commit", wr_seen, exp_wr);
    bus_read(16'h0003);
    bus_write(16'h0004, 32'h0BAD_F00D, 0);
    bus_read(16'h0004);

    // Extra clocks after a completed write (MSB 0 so a stray drive shows as 0).
    bus_write(16'h0005, 32'h1234_5678, 3);
    bus_read(16'h0005);

    // Reset in the middle of a read-data phase.
    send_hdr(TW_RW_READ, 16'h0003, AB);
    tb_oe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(h);
      in_tw_clock = 1'b1;
      tick(h);
      in_tw_clock = 1'b0;
    end
    in_reset = 1'b1;
    tick(1);
    check("midrst_line", io_tw_data, 1'b1);
    check("midrst_wr_valid", out_wr_valid, 1'b0);
    check("midrst_wr_addr", out_wr_addr, '0);
    check("midrst_wr_data", out_wr_data, '0);
    check("midrst_frame_err", out_frame_err, 1'b0);
    in_tw_cs = 1'b0;
    tick(h);
    in_reset = 1'b0;
    tick(h + 2);
    check("midrst_no_err", err_seen, exp_err);
    for (int i = 0; i < RC; i++) model[i] = '0;
    exp_addr = '0;
    exp_data = '0;
    bus_read(16'h0003);

    // Back-to-back random traffic at the minimum half-period.
    for (int n = 0; n < 100; n++) begin
      logic [AB-1:0] a;
      a = ($urandom_range(0, 9) == 0) ? AB'($urandom) : AB'($urandom_range(0, RC - 1));
      if ($urandom_range(0, 1) == 1) bus_write(a, $urandom, 0);
      else bus_read(a);
    end
    check("final_err_count", err_seen, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
